// File: rtl/misr_checker_if.sv
// Response/scan bundle between a BIST response source and misr_checker.
// master drives stimulus and scan input; slave (the checker) drives the signature and status.
interface misr_checker_if #(
   parameter int unsigned NBIT = 4
);
   logic            start;
   logic            valid_in;
   logic [NBIT-1:0] resp_in;
   logic            scan_en;
   logic            scan_in;
   logic [NBIT-1:0] signature;
   logic            scan_out;
   logic            busy;
   logic            done;
   logic            pass;

   modport master (
      output start, valid_in, resp_in, scan_en, scan_in,
      input  signature, scan_out, busy, done, pass
   );

   modport slave (
      input  start, valid_in, resp_in, scan_en, scan_in,
      output signature, scan_out, busy, done, pass
   );
endinterface

// File: rtl/misr_checker.sv
// MISR compactor: folds NPAT responses into a signature, checks it against GOLDEN, supports scan unload.
// Latency: done/pass one cycle after the last response; no backpressure, valid_in gaps simply stall compaction.
module misr_checker #(
   parameter int unsigned    NBIT   = 4,
   parameter int unsigned    NPAT   = 16,
   parameter logic [NBIT-1:0] SEED   = '0,
   parameter logic [NBIT-1:0] GOLDEN = '0
) (
   input  logic           clk,
   input  logic           rst,
   misr_checker_if.slave  bus
);
   localparam int unsigned CW = $clog2(NPAT + 1);
   localparam logic [CW-1:0] LAST = CW'(NPAT - 1);

   // Encoding chosen so busy is state[0] and done is state[2], straight off the register.
   localparam logic [2:0] S_IDLE    = 3'b000;
   localparam logic [2:0] S_COMPACT = 3'b001;
   localparam logic [2:0] S_CHECK   = 3'b011;
   localparam logic [2:0] S_DONE    = 3'b100;

   logic [2:0]      state;
   logic [NBIT-1:0] sig;
   logic [NBIT-1:0] sig_step;
   logic [CW-1:0]   cnt;
   logic            pass_r;

   always_comb begin
      sig_step       = '0;
      sig_step[0]    = sig[NBIT-1] ^ sig[NBIT-2] ^ bus.resp_in[0];
      sig_step[NBIT-1:1] = sig[NBIT-2:0] ^ bus.resp_in[NBIT-1:1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         sig    <= SEED;
         cnt    <= '0;
         pass_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state  <= S_COMPACT;
                  sig    <= SEED;
                  cnt    <= '0;
                  pass_r <= 1'b0;
               end else if (bus.scan_en) begin
                  sig <= {sig[NBIT-2:0], bus.scan_in};
               end
            end
            S_COMPACT: begin
               if (bus.valid_in) begin
                  sig <= sig_step;
                  // Hold the count on the last response so it never reaches NPAT.
                  if (cnt == LAST) begin
                     state <= S_CHECK;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_CHECK: begin
               pass_r <= (sig == GOLDEN);
               state  <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.signature = sig;
   assign bus.scan_out  = sig[NBIT-1];
   assign bus.busy      = state[0];
   assign bus.done      = state[2];
   assign bus.pass      = pass_r;
endmodule

// File: tb/tb_misr_checker.sv
// Directed bench for misr_checker: a cycle model tracks instance A, literal expectations pin key values.
module tb_misr_checker;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total  = 0;
   int   passed = 0;
   bit   cmp_en = 1'b0;

   always #5 clk = ~clk;

   misr_checker_if #(.NBIT(4)) if_a();
   misr_checker_if #(.NBIT(4)) if_b();
   misr_checker_if #(.NBIT(4)) if_c();

   misr_checker #(.NBIT(4), .NPAT(2),  .SEED(4'h0), .GOLDEN(4'h6)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   misr_checker #(.NBIT(4), .NPAT(1),  .SEED(4'hF), .GOLDEN(4'hE)) u_b (.clk(clk), .rst(rst), .bus(if_b));
   misr_checker #(.NBIT(4), .NPAT(16), .SEED(4'hA), .GOLDEN(4'h0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Signature update as a shift-left with feedback from the top two bits, then XOR the response.
   function automatic logic [3:0] misr_next(input logic [3:0] s, input logic [3:0] r);
      return {s[2:0], s[3] ^ s[2]} ^ r;
   endfunction

   // Model for instance A (NPAT=2, SEED=0, GOLDEN=6).
   logic [3:0] m_sig;
   int         m_n;
   bit         m_running, m_judging, m_done, m_pass;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_sig <= 4'h0; m_n <= 0; m_running <= 0; m_judging <= 0; m_done <= 0; m_pass <= 0;
      end else if (m_judging) begin
         m_pass <= (m_sig == 4'h6); m_judging <= 0; m_running <= 0; m_done <= 1;
      end else if (m_running) begin
         if (if_a.valid_in) begin
            m_sig <= misr_next(m_sig, if_a.resp_in);
            m_n   <= m_n + 1;
            if (m_n + 1 == 2) m_judging <= 1;
         end
      end else if (if_a.start) begin
         m_sig <= 4'h0; m_n <= 0; m_running <= 1; m_done <= 0; m_pass <= 0;
      end else if (if_a.scan_en) begin
         m_sig <= {m_sig[2:0], if_a.scan_in};
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_sig",  int'(if_a.signature), int'(m_sig));
         check("cyc_sout", int'(if_a.scan_out),  int'(m_sig[3]));
         check("cyc_busy", int'(if_a.busy),      int'(m_running));
         check("cyc_done", int'(if_a.done),      int'(m_done));
         check("cyc_pass", int'(if_a.pass),      int'(m_pass));
      end
   end

   task automatic start_a();
      if_a.start = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0;
   endtask

   task automatic send_a(input logic [3:0] r);
      if_a.valid_in = 1'b1;
      if_a.resp_in  = r;
      @(negedge clk);
      if_a.valid_in = 1'b0;
      if_a.resp_in  = 4'h0;
   endtask

   task automatic wait_done_a(output int cycles);
      cycles = 0;
      while (!if_a.done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      if (!if_a.done) check("done_timeout", 0, 1);
   endtask

   int cyc;

   initial begin
      {if_a.start, if_a.valid_in, if_a.resp_in, if_a.scan_en, if_a.scan_in} = '0;
      {if_b.start, if_b.valid_in, if_b.resp_in, if_b.scan_en, if_b.scan_in} = '0;
      {if_c.start, if_c.valid_in, if_c.resp_in, if_c.scan_en, if_c.scan_in} = '0;
      repeat (2) @(negedge clk);

      // Reset values while held in reset
      check("rst_sig",  int'(if_c.signature), 'hA);
      check("rst_sout", int'(if_c.scan_out), 1);
      check("rst_busy", int'(if_c.busy), 0);
      check("rst_done", int'(if_c.done), 0);
      check("rst_pass", int'(if_c.pass), 0);
      rst = 1'b1;
      @(negedge clk);
      cmp_en = 1'b1;
      check("rel_sig",  int'(if_c.signature), 'hA);
      check("rel_busy", int'(if_c.busy), 0);

      // Single step on instance B
      if_b.start = 1'b1;
      @(negedge clk);
      if_b.start = 1'b0;
      check("b_busy", int'(if_b.busy), 1);
      if_b.valid_in = 1'b1;
      if_b.resp_in  = 4'h0;
      @(negedge clk);
      if_b.valid_in = 1'b0;
      check("b_sig", int'(if_b.signature), 'hE);
      check("b_done_early", int'(if_b.done), 0);
      @(negedge clk);
      check("b_done", int'(if_b.done), 1);
      check("b_pass", int'(if_b.pass), 1);

      // Passing run on A
      start_a();
      send_a(4'h1);
      check("p_sig1", int'(if_a.signature), 'h1);
      send_a(4'h4);
      check("p_sig2", int'(if_a.signature), 'h6);
      wait_done_a(cyc);
      check("p_lat", cyc, 1);
      check("p_pass", int'(if_a.pass), 1);

      // Failing run; restart from DONE clears done/pass
      start_a();
      check("f_done_clr", int'(if_a.done), 0);
      check("f_pass_clr", int'(if_a.pass), 0);
      send_a(4'h1);
      send_a(4'h5);
      check("f_sig", int'(if_a.signature), 'h7);
      wait_done_a(cyc);
      check("f_pass", int'(if_a.pass), 0);

      // Gaps with start/scan_en pulses during COMPACT
      start_a();
      send_a(4'h1);
      if_a.start = 1'b1; if_a.scan_en = 1'b1; if_a.scan_in = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0; if_a.scan_en = 1'b0; if_a.scan_in = 1'b0;
      repeat (2) @(negedge clk);
      check("g_hold", int'(if_a.signature), 'h1);
      send_a(4'h4);
      wait_done_a(cyc);
      check("g_lat", cyc, 1);
      check("g_sig", int'(if_a.signature), 'h6);
      check("g_pass", int'(if_a.pass), 1);

      // Scan unload, MSB first
      check("s_out0", int'(if_a.scan_out), 0);
      if_a.scan_en = 1'b1; if_a.scan_in = 1'b0;
      @(negedge clk); check("s_out1", int'(if_a.scan_out), 1);
      @(negedge clk); check("s_out2", int'(if_a.scan_out), 1);
      @(negedge clk); check("s_out3", int'(if_a.scan_out), 0);
      @(negedge clk);
      if_a.scan_en = 1'b0;
      check("s_sig", int'(if_a.signature), 'h0);
      check("s_pass", int'(if_a.pass), 1);
      check("s_done", int'(if_a.done), 1);

      // Asynchronous reset mid-run
      start_a();
      send_a(4'h1);
      #2 rst = 1'b0;
      #1;
      check("r_busy", int'(if_a.busy), 0);
      check("r_sig",  int'(if_a.signature), 'h0);
      check("r_done", int'(if_a.done), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start_a();
      send_a(4'h1);
      send_a(4'h4);
      wait_done_a(cyc);
      check("r2_sig",  int'(if_a.signature), 'h6);
      check("r2_pass", int'(if_a.pass), 1);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
